// File: rtl/ram8_pkg.sv
// Shared definitions for the 8-word register RAM and its two-port arbiter.
package ram8_pkg;

  localparam int DEF_DATA_W = 16;
  localparam int DEF_ADDR_W = 3;

  // Sequencer states. The unused 2'd3 code is named so that the
  // next-state logic can steer it back to IDLE explicitly.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ACCESS  = 2'd1,
    ST_DONE    = 2'd2,
    ST_ILLEGAL = 2'd3
  } state_e;

  // Identifies which requester owns the transaction in flight.
  typedef enum logic {
    OWN_A = 1'b0,
    OWN_B = 1'b1
  } owner_e;

  // Returns the requester that did not win, used to flip the priority pointer.
  function automatic owner_e otherOwner(input owner_e o);
    return (o == OWN_A) ? OWN_B : OWN_A;
  endfunction

endpackage

// File: rtl/ram8_sync.sv
// Clocked storage: synchronous write, registered read, asynchronous clear.
module ram8_sync
  import ram8_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic              re_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wdata_i,
  output logic [DATA_W-1:0] rdata_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // Storage array and read register; reset wipes every word and the read result.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      rdata_q <= '0;
    end else begin
      if (we_i) begin
        mem_q[addr_i] <= wdata_i;
      end
      if (re_i) begin
        rdata_q <= mem_q[addr_i];
      end
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/ram8_arbiter.sv
// Two-requester round-robin arbiter and access sequencer for the 8-word RAM.
module ram8_arbiter
  import ram8_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_a_i,
  input  logic              we_a_i,
  input  logic [ADDR_W-1:0] addr_a_i,
  input  logic [DATA_W-1:0] wdata_a_i,
  input  logic              req_b_i,
  input  logic              we_b_i,
  input  logic [ADDR_W-1:0] addr_b_i,
  input  logic [DATA_W-1:0] wdata_b_i,
  output logic              ack_a_o,
  output logic              ack_b_o,
  output logic [DATA_W-1:0] rdata_o,
  output logic              busy_o
);

  state_e            state_q, state_d;
  owner_e            prio_q;
  owner_e            owner_q;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  logic              anyReq;
  owner_e            winner;
  logic              memWe;
  logic              memRe;

  assign anyReq = req_a_i | req_b_i;

  // B wins when it is alone or when both ask and the pointer favours B.
  always_comb begin
    winner = OWN_A;
    if (req_b_i && (!req_a_i || prio_q == OWN_B)) begin
      winner = OWN_B;
    end
  end

  // State register.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: fixed three-step walk once a request is accepted.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   state_d = anyReq ? ST_ACCESS : ST_IDLE;
      ST_ACCESS: state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Moore outputs: RAM strobes in ACCESS, owner's ack in DONE.
  always_comb begin
    memWe   = 1'b0;
    memRe   = 1'b0;
    ack_a_o = 1'b0;
    ack_b_o = 1'b0;
    busy_o  = 1'b0;
    case (state_q)
      ST_ACCESS: begin
        memWe  = we_q;
        memRe  = ~we_q;
        busy_o = 1'b1;
      end
      ST_DONE: begin
        ack_a_o = (owner_q == OWN_A);
        ack_b_o = (owner_q == OWN_B);
        busy_o  = 1'b1;
      end
      default: begin
        busy_o = 1'b0;
      end
    endcase
  end

  // Request latch: the winner's command is frozen at the IDLE->ACCESS edge so
  // later changes on the request inputs cannot disturb the access.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      owner_q <= OWN_A;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (state_q == ST_IDLE && anyReq) begin
      owner_q <= winner;
      if (winner == OWN_B) begin
        we_q    <= we_b_i;
        addr_q  <= addr_b_i;
        wdata_q <= wdata_b_i;
      end else begin
        we_q    <= we_a_i;
        addr_q  <= addr_a_i;
        wdata_q <= wdata_a_i;
      end
    end
  end

  // Round-robin pointer: after each completed transaction the loser gets priority.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      prio_q <= OWN_A;
    end else if (state_q == ST_DONE) begin
      prio_q <= otherOwner(owner_q);
    end
  end

  ram8_sync #(
    .DATA_W(DATA_W),
    .ADDR_W(ADDR_W)
  ) uRam (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .we_i   (memWe),
    .re_i   (memRe),
    .addr_i (addr_q),
    .wdata_i(wdata_q),
    .rdata_o(rdata_o)
  );

endmodule

// File: tb/tb_ram8_arbiter.sv
// Directed scoreboard bench for the two-requester RAM arbiter.
module tb_ram8_arbiter;

  logic        clock;
  logic        reset;
  logic        reqA, weA, reqB, weB;
  logic [2:0]  addrA, addrB;
  logic [15:0] wdataA, wdataB;
  logic        ackA, ackB, busy;
  logic [15:0] rdata;

  typedef struct packed {
    logic        owner;
    logic        isRead;
    logic [15:0] data;
  } expItem_t;

  expItem_t    expQ[$];
  logic [15:0] modelMem [8];
  logic        modelPrio;
  logic [15:0] modelRdata;
  int          checks;
  int          errors;

  ram8_arbiter dut (
    .clk_i    (clock),
    .reset_i  (reset),
    .req_a_i  (reqA),
    .we_a_i   (weA),
    .addr_a_i (addrA),
    .wdata_a_i(wdataA),
    .req_b_i  (reqB),
    .we_b_i   (weB),
    .addr_b_i (addrB),
    .wdata_b_i(wdataB),
    .ack_a_o  (ackA),
    .ack_b_o  (ackB),
    .rdata_o  (rdata),
    .busy_o   (busy)
  );

  // Free-running clock, 10 time units per period.
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 8; i++) modelMem[i] = 16'h0000;
    modelPrio  = 1'b0;
    modelRdata = 16'h0000;
  endtask

  // Predicts one transaction in grant order and queues its expected ack.
  task automatic expectTxn(input logic owner, input logic we, input logic [2:0] addr,
                           input logic [15:0] wdata);
    expItem_t e;
    if (we) modelMem[addr] = wdata;
    else    modelRdata = modelMem[addr];
    e.owner  = owner;
    e.isRead = ~we;
    e.data   = modelRdata;
    modelPrio = ~owner;
    expQ.push_back(e);
  endtask

  task automatic resetDut();
    reset = 1'b1;
    reqA = 1'b0;
    reqB = 1'b0;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    modelReset();
    expQ.delete();
    @(negedge clock);
    checkVal("reset busy", busy, 0);
    checkVal("reset ackA", ackA, 0);
    checkVal("reset ackB", ackB, 0);
    checkVal("reset rdata", rdata, 0);
  endtask

  // Drives one or both requesters and queues expectations in arbitration order.
  task automatic applyStimulus(input logic rA, input logic wA, input logic [2:0] aA,
                               input logic [15:0] dA, input logic rB, input logic wB,
                               input logic [2:0] aB, input logic [15:0] dB);
    reqA = rA; weA = wA; addrA = aA; wdataA = dA;
    reqB = rB; weB = wB; addrB = aB; wdataB = dB;
    if (rA && rB) begin
      if (modelPrio) begin
        expectTxn(1'b1, wB, aB, dB);
        expectTxn(1'b0, wA, aA, dA);
      end else begin
        expectTxn(1'b0, wA, aA, dA);
        expectTxn(1'b1, wB, aB, dB);
      end
    end else if (rA) begin
      expectTxn(1'b0, wA, aA, dA);
    end else if (rB) begin
      expectTxn(1'b1, wB, aB, dB);
    end
  endtask

  // Waits (bounded) for the next ack and compares it with the queue head.
  task automatic checkOutput(input int expCycles, input bit keepReq, input string tag);
    int       n;
    bit       got;
    expItem_t e;
    n   = 0;
    got = 0;
    while (!got && n < 12) begin
      @(negedge clock);
      n++;
      if (ackA || ackB) begin
        got = 1;
        checkVal({tag, " ack exclusive"}, ackA & ackB, 0);
        checks++;
        assert (expQ.size() != 0) else begin
          errors++;
          $error("[TB] FAIL %s unexpected ack: observed ackA=%0b ackB=%0b expected none", tag, ackA, ackB);
        end
        if (expQ.size() != 0) begin
          e = expQ.pop_front();
          checkVal({tag, " owner"}, ackB, e.owner);
          checkVal({tag, " rdata"}, rdata, e.data);
        end
        if (expCycles >= 0) checkVal({tag, " latency"}, n, expCycles);
        if (!keepReq) begin
          if (ackA) reqA = 1'b0;
          if (ackB) reqB = 1'b0;
        end
      end
    end
    checks++;
    assert (got) else begin
      errors++;
      $error("[TB] FAIL %s timeout: observed no ack expected ack within 12 cycles", tag);
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    reqA = 0; weA = 0; addrA = 0; wdataA = 0;
    reqB = 0; weB = 0; addrB = 0; wdataB = 0;
    modelReset();

    // Test 1: reset values, then a read of cleared addr 5 with busy profile.
    resetDut();
    applyStimulus(1, 0, 3'd5, 16'h0, 0, 0, 3'd0, 16'h0);
    @(negedge clock);
    checkVal("t1 busy access", busy, 1);
    checkVal("t1 no early ack", ackA, 0);
    checkOutput(1, 0, "t1 read5");
    checkVal("t1 busy done", busy, 1);
    @(negedge clock);
    checkVal("t1 busy idle", busy, 0);

    // Test 2: A writes then reads addr 3; rdata holds across the write ack.
    applyStimulus(1, 1, 3'd3, 16'h1234, 0, 0, 3'd0, 16'h0);
    checkOutput(2, 0, "t2 write3");
    @(negedge clock);
    applyStimulus(1, 0, 3'd3, 16'h0, 0, 0, 3'd0, 16'h0);
    checkOutput(2, 0, "t2 read3");

    // Test 3: simultaneous pair after reset (A first), then after an A-only grant B first.
    resetDut();
    applyStimulus(1, 1, 3'd1, 16'h1111, 1, 0, 3'd1, 16'h0);
    checkOutput(2, 0, "t3 pair1 first");
    checkOutput(3, 0, "t3 pair1 second");
    @(negedge clock);
    applyStimulus(1, 0, 3'd1, 16'h0, 0, 0, 3'd0, 16'h0);
    checkOutput(2, 0, "t3 a only");
    @(negedge clock);
    applyStimulus(1, 0, 3'd1, 16'h0, 1, 1, 3'd1, 16'h2222);
    checkOutput(2, 0, "t3 pair2 first");
    checkOutput(3, 0, "t3 pair2 second");

    // Test 4: B held high streams every 3 cycles; raising A takes the next grant.
    @(negedge clock);
    applyStimulus(0, 0, 3'd0, 16'h0, 1, 0, 3'd1, 16'h0);
    checkOutput(2, 1, "t4 b stream0");
    expectTxn(1'b1, 1'b0, 3'd1, 16'h0);
    checkOutput(3, 1, "t4 b stream1");
    expectTxn(1'b1, 1'b0, 3'd1, 16'h0);
    checkOutput(3, 1, "t4 b stream2");
    reqA = 1'b1; weA = 1'b1; addrA = 3'd4; wdataA = 16'h0A0A;
    expectTxn(1'b0, 1'b1, 3'd4, 16'h0A0A);
    expectTxn(1'b1, 1'b0, 3'd1, 16'h0);
    checkOutput(3, 0, "t4 a preempt");
    checkOutput(3, 0, "t4 b after a");

    // Test 5: same-cycle A write / B read of addr 7, serialised A then B.
    resetDut();
    applyStimulus(1, 1, 3'd7, 16'hBEEF, 1, 0, 3'd7, 16'h0);
    checkOutput(2, 0, "t5 a write7");
    checkOutput(3, 0, "t5 b read7");

    // Test 6: reset during ACCESS of an A write drops it without an ack.
    @(negedge clock);
    reqA = 1'b1; weA = 1'b1; addrA = 3'd2; wdataA = 16'hCAFE;
    @(negedge clock);
    checkVal("t6 in access", busy, 1);
    reset = 1'b1;
    reqA  = 1'b0;
    #1;
    checkVal("t6 async busy", busy, 0);
    checkVal("t6 async rdata", rdata, 0);
    @(negedge clock);
    reset = 1'b0;
    modelReset();
    expQ.delete();
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checkVal("t6 no ackA", ackA, 0);
    end
    applyStimulus(1, 0, 3'd2, 16'h0, 0, 0, 3'd0, 16'h0);
    checkOutput(2, 0, "t6 read2");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
